// File: rtl/stage4_mem_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
// Holds the mem-op encoding, FSM state type, size codes and the NaN-box constant.
package stage4_mem_pkg;

    // type_op_mem_ex layout: [4] mem valid, [3] store, [2:0] size/sign code
    typedef struct packed {
        logic       valid;
        logic       store;
        logic [2:0] size;
    } mem_op_t;

    localparam logic [2:0] SzB  = 3'b000;
    localparam logic [2:0] SzH  = 3'b001;
    localparam logic [2:0] SzW  = 3'b010;
    localparam logic [2:0] SzD  = 3'b011;
    localparam logic [2:0] SzBu = 3'b100;
    localparam logic [2:0] SzHu = 3'b101;
    localparam logic [2:0] SzWu = 3'b110;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } mem_state_t;

    localparam logic [31:0] NanBoxHi = 32'hFFFF_FFFF;

    // Address bits that must be zero for a naturally aligned access of this size.
    function automatic logic [2:0] align_mask(input logic [2:0] size);
        case (size)
            SzH, SzHu: align_mask = 3'b001;
            SzW, SzWu: align_mask = 3'b011;
            SzD:       align_mask = 3'b111;
            default:   align_mask = 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] size_strobe(input logic [2:0] size);
        case (size)
            SzH, SzHu: size_strobe = 8'h03;
            SzW, SzWu: size_strobe = 8'h0F;
            SzD:       size_strobe = 8'hFF;
            default:   size_strobe = 8'h01;
        endcase
    endfunction

endpackage

// File: rtl/stage4_mem_if.sv
// Data-memory bus: valid/ready request channel plus a valid-only response channel.
// The pipeline stage drives the master side; the memory model/controller is the slave.
interface stage4_mem_if #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ADDR_W = 48
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [7:0]        req_wstrb;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/stage4_mem_align.sv
// Combinational lane logic: store data/strobe placement and load extract, extend, NaN-box.
// Offset is assumed already aligned to the access size by the caller.
module stage4_mem_align
    import stage4_mem_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [2:0]      size_i,
    input  logic [2:0]      offset_i,
    input  logic            fp_i,
    input  logic [XLEN-1:0] st_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] wdata_o,
    output logic [7:0]      wstrb_o,
    output logic [XLEN-1:0] ld_data_o
);

    logic [5:0]      bit_sh;
    logic [XLEN-1:0] sh;

    assign bit_sh = {offset_i, 3'b000};

    always_comb begin
        wdata_o   = st_data_i << bit_sh;
        wstrb_o   = size_strobe(size_i) << offset_i;
        sh        = rdata_i >> bit_sh;
        ld_data_o = sh;
        case (size_i)
            SzB:  ld_data_o = {{(XLEN-8){sh[7]}}, sh[7:0]};
            SzH:  ld_data_o = {{(XLEN-16){sh[15]}}, sh[15:0]};
            SzW: begin
                // Single-precision values in the FP file are NaN-boxed.
                if (fp_i) ld_data_o = {NanBoxHi, sh[31:0]};
                else      ld_data_o = {{(XLEN-32){sh[31]}}, sh[31:0]};
            end
            SzBu: ld_data_o = {{(XLEN-8){1'b0}}, sh[7:0]};
            SzHu: ld_data_o = {{(XLEN-16){1'b0}}, sh[15:0]};
            SzWu: ld_data_o = {{(XLEN-32){1'b0}}, sh[31:0]};
            default: ld_data_o = sh;
        endcase
    end

endmodule

// File: rtl/stage4_mem.sv
// Memory-access stage: issues loads/stores on the dmem bus and registers MEM results.
// Optional macro STAGE4_MISALIGN_TRAP_EN traps misaligned accesses instead of force-aligning.
module stage4_mem
    import stage4_mem_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned ADDR_W      = 48,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        rd_ex,
    input  logic [XLEN-1:0]   op_ex,
    input  logic              we_rd_ex,
    input  logic [ADDR_W-1:0] mem_addr_ex,
    input  logic              reg_type_ex,
    input  logic [4:0]        type_op_mem_ex,
    input  logic              trap_if_dec_ex,
    input  logic              trap_dec_ex,
    input  logic              trap_ex,
    output logic              stall_mem,
    stage4_mem_if.master      dmem,
    output logic [4:0]        rd_mem,
    output logic [XLEN-1:0]   op_mem,
    output logic              we_rd_mem,
    output logic              reg_type_mem,
    output logic              trap_if_dec_mem,
    output logic              trap_dec_mem,
    output logic              trap_ex_mem,
    output logic              trap_mem
);

    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYC - 1);

    mem_state_t        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    mem_op_t           op_fields;
    logic              is_mem, mis_trap, start, timeout;
    logic [ADDR_W-1:0] eff_addr;
    logic              req_valid, store_done, load_done, tmo;
    logic [XLEN-1:0]   ld_data, st_wdata;
    logic [7:0]        st_wstrb;

    logic [4:0]        rd_mem_q, rd_mem_d;
    logic [XLEN-1:0]   op_mem_q, op_mem_d;
    logic              we_rd_mem_q, we_rd_mem_d;
    logic              reg_type_mem_q, reg_type_mem_d;
    logic              trap_if_dec_mem_q, trap_if_dec_mem_d;
    logic              trap_dec_mem_q, trap_dec_mem_d;
    logic              trap_ex_mem_q, trap_ex_mem_d;
    logic              trap_mem_q, trap_mem_d;

    always_comb begin
        op_fields = mem_op_t'(type_op_mem_ex);
        // Upstream traps kill the access; the instruction just flows through.
        is_mem    = op_fields.valid & ~(trap_if_dec_ex | trap_dec_ex | trap_ex);
`ifdef STAGE4_MISALIGN_TRAP_EN
        mis_trap  = is_mem & (|(mem_addr_ex[2:0] & align_mask(op_fields.size)));
        eff_addr  = mem_addr_ex;
`else
        mis_trap  = 1'b0;
        eff_addr  = {mem_addr_ex[ADDR_W-1:3], mem_addr_ex[2:0] & ~align_mask(op_fields.size)};
`endif
        start     = is_mem & ~mis_trap;
    end

    assign timeout = (state_q != StIdle) && (cnt_q == TmoLast);

    // IDLE behaves as REQ in the cycle a mem op arrives, so a ready slave
    // can accept a store with no stall at all.
    always_comb begin
        state_d    = state_q;
        req_valid  = 1'b0;
        stall_mem  = 1'b0;
        store_done = 1'b0;
        load_done  = 1'b0;
        tmo        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    req_valid = 1'b1;
                    if (dmem.req_ready) begin
                        if (op_fields.store) begin
                            store_done = 1'b1;
                        end else begin
                            state_d   = StWait;
                            stall_mem = 1'b1;
                        end
                    end else begin
                        state_d   = StReq;
                        stall_mem = 1'b1;
                    end
                end
            end
            StReq: begin
                if (timeout) begin
                    tmo     = 1'b1;
                    state_d = StIdle;
                end else begin
                    req_valid = 1'b1;
                    if (dmem.req_ready) begin
                        if (op_fields.store) begin
                            store_done = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            state_d   = StWait;
                            stall_mem = 1'b1;
                        end
                    end else begin
                        stall_mem = 1'b1;
                    end
                end
            end
            StWait: begin
                if (dmem.rsp_valid) begin
                    load_done = 1'b1;
                    state_d   = StIdle;
                end else if (timeout) begin
                    tmo     = 1'b1;
                    state_d = StIdle;
                end else begin
                    stall_mem = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StIdle)      cnt_d = '0;
        else if (state_q == StIdle) cnt_d = 8'd1;
        else                        cnt_d = cnt_q + 8'd1;
    end

    stage4_mem_align #(
        .XLEN(XLEN)
    ) u_align (
        .size_i   (op_fields.size),
        .offset_i (eff_addr[2:0]),
        .fp_i     (reg_type_ex),
        .st_data_i(op_ex),
        .rdata_i  (dmem.rsp_rdata),
        .wdata_o  (st_wdata),
        .wstrb_o  (st_wstrb),
        .ld_data_o(ld_data)
    );

    assign dmem.req_valid = req_valid;
    assign dmem.req_we    = op_fields.store;
    assign dmem.req_addr  = {eff_addr[ADDR_W-1:3], 3'b000};
    assign dmem.req_wdata = st_wdata;
    assign dmem.req_wstrb = st_wstrb;

    always_comb begin
        rd_mem_d          = rd_ex;
        op_mem_d          = op_ex;
        we_rd_mem_d       = we_rd_ex;
        reg_type_mem_d    = reg_type_ex;
        trap_if_dec_mem_d = trap_if_dec_ex;
        trap_dec_mem_d    = trap_dec_ex;
        trap_ex_mem_d     = trap_ex;
        trap_mem_d        = 1'b0;
        // Bubble while stalled; stores and local traps write nothing back.
        if (stall_mem || tmo || mis_trap || store_done) begin
            rd_mem_d          = '0;
            op_mem_d          = '0;
            we_rd_mem_d       = 1'b0;
            reg_type_mem_d    = 1'b0;
            trap_if_dec_mem_d = 1'b0;
            trap_dec_mem_d    = 1'b0;
            trap_ex_mem_d     = 1'b0;
            trap_mem_d        = ~stall_mem & (tmo | mis_trap);
        end else if (load_done) begin
            op_mem_d = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= StIdle;
            cnt_q             <= '0;
            rd_mem_q          <= '0;
            op_mem_q          <= '0;
            we_rd_mem_q       <= 1'b0;
            reg_type_mem_q    <= 1'b0;
            trap_if_dec_mem_q <= 1'b0;
            trap_dec_mem_q    <= 1'b0;
            trap_ex_mem_q     <= 1'b0;
            trap_mem_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            rd_mem_q          <= rd_mem_d;
            op_mem_q          <= op_mem_d;
            we_rd_mem_q       <= we_rd_mem_d;
            reg_type_mem_q    <= reg_type_mem_d;
            trap_if_dec_mem_q <= trap_if_dec_mem_d;
            trap_dec_mem_q    <= trap_dec_mem_d;
            trap_ex_mem_q     <= trap_ex_mem_d;
            trap_mem_q        <= trap_mem_d;
        end
    end

    assign rd_mem          = rd_mem_q;
    assign op_mem          = op_mem_q;
    assign we_rd_mem       = we_rd_mem_q;
    assign reg_type_mem    = reg_type_mem_q;
    assign trap_if_dec_mem = trap_if_dec_mem_q;
    assign trap_dec_mem    = trap_dec_mem_q;
    assign trap_ex_mem     = trap_ex_mem_q;
    assign trap_mem        = trap_mem_q;

endmodule
